// File: rtl/inst_fetch_pkg.sv
// Shared CPU definitions for the instruction fetch stage.
// Holds the fetch FSM state encoding and the architectural PC constants.
// No logic; imported by the fetch stage.
package inst_fetch_pkg;

    typedef enum logic [1:0] {
        S_REQ     = 2'd0,
        S_WAIT    = 2'd1,
        S_HOLD    = 2'd2,
        S_DISCARD = 2'd3
    } fetch_state_t;

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
    localparam logic [31:0] PC_STEP  = 32'd4;

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch: issues one request at a time to the instruction memory bridge.
// Latency: addr_ok to if_valid is at least 2 cycles; redirects discard any fetch in flight.
// Backpressure: if_id_stall holds the fetched instruction in HOLD; no new request until consumed.
module inst_fetch
    import inst_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    input  logic        if_id_stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_valid,
    output logic        if_adel
);

    fetch_state_t state, state_nxt;
    logic [31:0]  pc, pc_nxt;
    logic [31:0]  inst_buf, inst_buf_nxt;
    logic [31:0]  pend_pc, pend_pc_nxt;
    logic         adel, adel_nxt;
    logic         pc_misaligned;

    assign pc_misaligned = (pc[1:0] != 2'b00);

    // Outputs depend only on registered state; rst masks them while reset is applied.
    assign inst_req  = !rst && (state == S_REQ) && !pc_misaligned;
    assign inst_addr = pc;
    assign if_valid  = !rst && (state == S_HOLD);
    assign if_adel   = !rst && (state == S_HOLD) && adel;
    assign if_inst   = inst_buf;
    assign if_pc     = pc;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_REQ;
            pc       <= RESET_PC;
            inst_buf <= 32'd0;
            pend_pc  <= 32'd0;
            adel     <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            inst_buf <= inst_buf_nxt;
            pend_pc  <= pend_pc_nxt;
            adel     <= adel_nxt;
        end
    end

    // Next-state logic; a redirect always wins over the normal flow.
    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        inst_buf_nxt = inst_buf;
        pend_pc_nxt  = pend_pc;
        adel_nxt     = adel;
        unique case (state)
            S_REQ: begin
                if (redirect) begin
                    // An accepted request must have its response thrown away.
                    if (inst_addr_ok && !pc_misaligned) begin
                        pend_pc_nxt = redirect_pc;
                        state_nxt   = S_DISCARD;
                    end else begin
                        pc_nxt = redirect_pc;
                    end
                end else if (pc_misaligned) begin
                    inst_buf_nxt = 32'd0;
                    adel_nxt     = 1'b1;
                    state_nxt    = S_HOLD;
                end else if (inst_addr_ok) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    if (inst_data_ok) begin
                        pc_nxt    = redirect_pc;
                        state_nxt = S_REQ;
                    end else begin
                        pend_pc_nxt = redirect_pc;
                        state_nxt   = S_DISCARD;
                    end
                end else if (inst_data_ok) begin
                    inst_buf_nxt = inst_rdata;
                    state_nxt    = S_HOLD;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_nxt    = redirect_pc;
                    adel_nxt  = 1'b0;
                    state_nxt = S_REQ;
                end else if (!if_id_stall) begin
                    pc_nxt    = pc + PC_STEP;
                    adel_nxt  = 1'b0;
                    state_nxt = S_REQ;
                end
            end
            S_DISCARD: begin
                if (inst_data_ok) begin
                    pc_nxt    = redirect ? redirect_pc : pend_pc;
                    state_nxt = S_REQ;
                end else if (redirect) begin
                    pend_pc_nxt = redirect_pc;
                end
            end
            default: state_nxt = S_REQ;
        endcase
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: reset, normal fetch, stall, redirects, misaligned PC, PC wrap.
// Inputs change 1 ns after the rising edge; outputs are checked there too.
// Expected values are hand-computed constants.
module tb_inst_fetch;
    import inst_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        if_id_stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;
    logic        if_adel;

    int n_total = 0;
    int n_pass  = 0;

    inst_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .if_id_stall  (if_id_stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .if_pc        (if_pc),
        .if_inst      (if_inst),
        .if_valid     (if_valid),
        .if_adel      (if_adel)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        rst          = 1'b1;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata   = 32'd0;
        if_id_stall  = 1'b0;
        redirect     = 1'b0;
        redirect_pc  = 32'd0;

        // Reset
        step(); step();
        chk("rst_req",   32'(inst_req), 32'd0);
        chk("rst_valid", 32'(if_valid), 32'd0);
        chk("rst_adel",  32'(if_adel),  32'd0);
        chk("rst_addr",  inst_addr,     32'hBFC0_0000);

        // First fetch after reset release, addr_ok immediately
        rst = 1'b0;
        #1;
        chk("first_req",  32'(inst_req), 32'd1);
        chk("first_addr", inst_addr,     32'hBFC0_0000);
        inst_addr_ok = 1'b1;
        step();
        inst_addr_ok = 1'b0;
        chk("wait_req", 32'(inst_req), 32'd0);
        step();
        inst_data_ok = 1'b1; inst_rdata = 32'h2408_0001;
        chk("wait_novalid", 32'(if_valid), 32'd0);
        step();
        inst_data_ok = 1'b0; inst_rdata = 32'd0;
        chk("hold_valid", 32'(if_valid), 32'd1);
        chk("hold_inst",  if_inst,       32'h2408_0001);
        chk("hold_pc",    if_pc,         32'hBFC0_0000);
        step();
        chk("next_req",  32'(inst_req), 32'd1);
        chk("next_addr", inst_addr,     32'hBFC0_0004);

        // Second fetch, then stall in HOLD for 5 cycles
        inst_addr_ok = 1'b1;
        step();
        inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h1111_2222;
        step();
        inst_data_ok = 1'b0; if_id_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 32'(if_valid), 32'd1);
            chk("stall_inst",  if_inst,       32'h1111_2222);
            chk("stall_pc",    if_pc,         32'hBFC0_0004);
            chk("stall_req",   32'(inst_req), 32'd0);
            step();
        end
        if_id_stall = 1'b0;
        chk("stall_last_valid", 32'(if_valid), 32'd1);
        step();
        chk("unstall_req",  32'(inst_req), 32'd1);
        chk("unstall_addr", inst_addr,     32'hBFC0_0008);

        // Redirect in WAIT without data; data arrives 3 cycles later and is dropped
        inst_addr_ok = 1'b1;
        step();
        inst_addr_ok = 1'b0; redirect = 1'b1; redirect_pc = 32'h8000_0180;
        step();
        redirect = 1'b0;
        chk("disc_req", 32'(inst_req), 32'd0);
        step();
        chk("disc_valid1", 32'(if_valid), 32'd0);
        step();
        inst_data_ok = 1'b1; inst_rdata = 32'hDEAD_BEEF;
        chk("disc_valid2", 32'(if_valid), 32'd0);
        step();
        inst_data_ok = 1'b0;
        chk("disc_out_valid", 32'(if_valid), 32'd0);
        chk("disc_out_req",   32'(inst_req), 32'd1);
        chk("disc_out_addr",  inst_addr,     32'h8000_0180);

        // Redirect and data_ok in the same WAIT cycle
        inst_addr_ok = 1'b1;
        step();
        inst_addr_ok = 1'b0; redirect = 1'b1; redirect_pc = 32'h8000_1000;
        inst_data_ok = 1'b1; inst_rdata = 32'hBAD0_BAD0;
        step();
        redirect = 1'b0; inst_data_ok = 1'b0;
        chk("same_valid", 32'(if_valid), 32'd0);
        chk("same_req",   32'(inst_req), 32'd1);
        chk("same_addr",  inst_addr,     32'h8000_1000);

        // Redirect into DISCARD, then two more redirects while discarding
        inst_addr_ok = 1'b1;
        step();
        inst_addr_ok = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0FF0;
        step();
        redirect_pc = 32'h0000_1000;
        step();
        redirect_pc = 32'h0000_2000;
        step();
        redirect = 1'b0;
        chk("dd_req", 32'(inst_req), 32'd0);
        inst_data_ok = 1'b1; inst_rdata = 32'h5555_5555;
        step();
        inst_data_ok = 1'b0;
        chk("dd_out_req",   32'(inst_req), 32'd1);
        chk("dd_out_addr",  inst_addr,     32'h0000_2000);
        chk("dd_out_valid", 32'(if_valid), 32'd0);

        // Redirect in REQ without addr_ok to a misaligned target
        redirect = 1'b1; redirect_pc = 32'h8000_0002;
        step();
        redirect = 1'b0;
        chk("mis_addr", inst_addr,     32'h8000_0002);
        chk("mis_req",  32'(inst_req), 32'd0);
        step();
        if_id_stall = 1'b1;
        chk("adel_valid", 32'(if_valid), 32'd1);
        chk("adel_flag",  32'(if_adel),  32'd1);
        chk("adel_inst",  if_inst,       32'd0);
        chk("adel_pc",    if_pc,         32'h8000_0002);
        step();
        chk("adel_stall_flag", 32'(if_adel), 32'd1);
        if_id_stall = 1'b0; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        chk("adel_clear", 32'(if_adel),  32'd0);
        chk("wrap_addr",  inst_addr,     32'hFFFF_FFFC);
        chk("wrap_req",   32'(inst_req), 32'd1);

        // Fetch at 0xFFFFFFFC, consume, PC wraps to zero
        inst_addr_ok = 1'b1;
        step();
        inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h0000_000F;
        step();
        inst_data_ok = 1'b0;
        chk("wrap_hold_pc",   if_pc,   32'hFFFF_FFFC);
        chk("wrap_hold_inst", if_inst, 32'h0000_000F);
        step();
        chk("wrap_next_addr", inst_addr,     32'h0000_0000);
        chk("wrap_next_req",  32'(inst_req), 32'd1);

        // Reset mid-run restores the reset PC
        rst = 1'b1;
        step();
        chk("rerst_req",  32'(inst_req), 32'd0);
        chk("rerst_addr", inst_addr,     32'hBFC0_0000);
        rst = 1'b0;
        #1;
        chk("rerst_rel_req", 32'(inst_req), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports in this order:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
REQ-002 The block SHALL expose the fetch port to the instruction memory bridge:
- inst_req  out  1  fetch request valid.
- inst_addr  out  32  fetch byte address.
- inst_addr_ok  in  1  address accepted this cycle.
- inst_data_ok  in  1  returned data valid this cycle.
- inst_rdata  in  32  returned instruction.
REQ-003 The block SHALL expose the pipeline control port:
- if_id_stall  in  1  IF/ID hold from the pipeline control unit.
- redirect  in  1  PC redirect this cycle (branch, exception entry or eret; already prioritised upstream).
- redirect_pc  in  32  redirect target.
REQ-004 The block SHALL expose the outputs to IF/ID:
- if_pc  out  32  PC of the held instruction.
- if_inst  out  32  held instruction.
- if_valid  out  1  if_inst/if_pc valid; drives the control unit's inst_data_ok.
- if_adel  out  1  fetch address error flag.

Function
REQ-005 States SHALL be REQ, WAIT, HOLD and DISCARD; only one request SHALL be outstanding.
REQ-006 In REQ, the block SHALL assert inst_req=1 with inst_addr=pc; on inst_addr_ok it SHALL go to WAIT.
REQ-007 In REQ with redirect and !inst_addr_ok, the block SHALL set pc<=redirect_pc and stay in REQ; with redirect and inst_addr_ok, it SHALL set pend<=redirect_pc and go to DISCARD.
REQ-008 In WAIT, inst_req SHALL be 0; on inst_data_ok with no redirect, the block SHALL set buf<=inst_rdata and go to HOLD (if_valid is 1 from the next cycle: addr_ok to if_valid is at least 2 cycles).
REQ-009 In WAIT, redirect with inst_data_ok SHALL drop the data, set pc<=redirect_pc and go to REQ; redirect without inst_data_ok SHALL set pend<=redirect_pc and go to DISCARD.
REQ-010 HOLD SHALL be the only state with if_valid=1; if_inst=buf; if_pc=pc.
REQ-011 In HOLD with !if_id_stall and no redirect, the block SHALL set pc<=pc+4 (mod 2^32, 0xFFFFFFFC wraps to 0x00000000) and go to REQ; with if_id_stall it SHALL stay in HOLD.
REQ-012 In HOLD, redirect SHALL take priority over consume: pc<=redirect_pc, go to REQ, no increment.
REQ-013 In DISCARD, inst_req SHALL be 0; inst_data_ok SHALL be dropped, pc<=pend, go to REQ; a redirect in DISCARD SHALL overwrite pend (latest wins); simultaneous redirect and inst_data_ok SHALL set pc<=redirect_pc and go to REQ.
REQ-014 In REQ with pc[1:0]!=0, the block SHALL issue no request and go directly to HOLD with buf=0 and if_adel=1; if_adel SHALL clear when HOLD is left.
REQ-015 inst_addr SHALL equal pc in every cycle; outputs SHALL be registered or pure functions of state and registers, with no inst_* input reaching an output combinationally.

Reset
REQ-016 While rst=1, the block SHALL set state=REQ, pc=0xBFC00000, buf=0, pend=0 and drive inst_req=0, if_valid=0, if_adel=0.
REQ-017 inst_req SHALL first assert in the first cycle after rst deasserts; a response belonging to a request in flight at reset is not produced by the bridge, and none is expected.

Structure
REQ-018 The shared cpu package SHALL hold the state enum, RESET_PC=32'hBFC00000 and PC_STEP=4.
REQ-019 The block SHALL be a single module; no sub-module is needed.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Reset release, addr_ok after 0 cycles, data_ok 2 cycles later with 0x24080001 -> inst_addr=0xBFC00000, if_valid then if_inst=0x24080001, if_pc=0xBFC00000; next request at 0xBFC00004.
- HOLD with if_id_stall=1 for 5 cycles -> if_inst/if_pc stable, inst_req=0; stall drop -> request at pc+4 next cycle.
- Redirect to 0x80000180 while in WAIT, data_ok 3 cycles later -> that data is never visible; next inst_addr=0x80000180.
- Redirect to 0x80001000 and data_ok in the same WAIT cycle -> data dropped, REQ at 0x80001000 next cycle.
- Two redirects in DISCARD (0x1000 then 0x2000) -> fetch at 0x2000 only.
- redirect_pc=0x80000002 -> no inst_req, if_valid=1, if_adel=1, if_inst=0; pc=0xFFFFFFFC consumed -> next inst_addr=0x00000000.
